sad_search_ctrl: RTL and testbench

Sequencer for the integer-pel motion-estimation SAD datapath. On `start` it walks every candidate motion vector of a square search window in raster order and issues one request per candidate to the 16x16 PE array / SAD adder tree. It then collects the 16x16 SAD for that candidate and tracks the minimum-cost vector. It sits between the macroblock-level encoder control and the SAD datapath, and reports the best motion vector and its SAD.

---
 rtl/sad_search_ctrl.sv | 152 +++++++++++++++
 tb/tb_sad_search_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// Integer-pel motion-search sequencer: raster-walks every candidate MV of the
// search window, requests its 16x16 SAD and reports the minimum-cost vector.
module sad_search_ctrl #(
   parameter  int SEARCH_RANGE = 16,
   parameter  int SAD_WIDTH    = 16,
   localparam int MV_W         = $clog2(SEARCH_RANGE) + 1,
   localparam int CNT_W        = 2 * MV_W + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   output logic                   pe_req,
   output logic signed [MV_W-1:0] pe_mvx,
   output logic signed [MV_W-1:0] pe_mvy,
   input  logic                   sad_valid,
   input  logic [SAD_WIDTH-1:0]   sad_in,
   output logic                   busy,
   output logic                   done,
   output logic signed [MV_W-1:0] best_mvx,
   output logic signed [MV_W-1:0] best_mvy,
   output logic [SAD_WIDTH-1:0]   best_sad,
   output logic [CNT_W-1:0]       eval_count
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_DONE} state_t;

   localparam logic signed [MV_W-1:0] MV_MIN  = {1'b1, {(MV_W-1){1'b0}}};
   localparam logic signed [MV_W-1:0] MV_MAX  = {1'b0, {(MV_W-1){1'b1}}};
   localparam logic signed [MV_W-1:0] MV_ONE  = {{(MV_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]       CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                 state;
   logic                   first;
   logic [CNT_W-1:0]       cnt;
   logic [SAD_WIDTH-1:0]   lat_sad;
   logic [SAD_WIDTH-1:0]   int_sad;
   logic signed [MV_W-1:0] int_mvx;
   logic signed [MV_W-1:0] int_mvy;

   logic [MV_W:0]          cand_l1;
   logic [MV_W:0]          best_l1;
   logic                   take;
   logic                   finish;
   logic signed [MV_W-1:0] win_mvx;
   logic signed [MV_W-1:0] win_mvy;
   logic [SAD_WIDTH-1:0]   win_sad;
   logic signed [MV_W-1:0] nxt_mvx;
   logic signed [MV_W-1:0] nxt_mvy;
   logic [CNT_W-1:0]       cnt_inc;

   // |v| of -R is R, which still fits MV_W unsigned bits.
   function automatic logic [MV_W:0] mag(input logic signed [MV_W-1:0] v);
      logic [MV_W-1:0] m;
      m = v[MV_W-1] ? -v : v;
      return {1'b0, m};
   endfunction

   // pe_mvx/pe_mvy double as the candidate counters.
   always_comb begin
      cand_l1 = mag(pe_mvx) + mag(pe_mvy);
      best_l1 = mag(int_mvx) + mag(int_mvy);
      take    = first || (lat_sad < int_sad) ||
                ((lat_sad == int_sad) && (cand_l1 < best_l1));
      win_mvx = take ? pe_mvx  : int_mvx;
      win_mvy = take ? pe_mvy  : int_mvy;
      win_sad = take ? lat_sad : int_sad;
      finish  = (lat_sad == '0) || ((pe_mvx == MV_MAX) && (pe_mvy == MV_MAX));
      // two's-complement wrap takes R-1 straight to -R
      nxt_mvx = pe_mvx + MV_ONE;
      nxt_mvy = (pe_mvx == MV_MAX) ? pe_mvy + MV_ONE : pe_mvy;
      cnt_inc = cnt + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pe_req     <= 1'b0;
         pe_mvx     <= '0;
         pe_mvy     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         best_mvx   <= '0;
         best_mvy   <= '0;
         best_sad   <= '0;
         eval_count <= '0;
         first      <= 1'b0;
         cnt        <= '0;
         lat_sad    <= '0;
         int_sad    <= '0;
         int_mvx    <= '0;
         int_mvy    <= '0;
      end else begin
         pe_req <= 1'b0;
         done   <= 1'b0;
         if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     pe_mvx <= MV_MIN;
                     pe_mvy <= MV_MIN;
                     cnt    <= '0;
                     first  <= 1'b1;
                     pe_req <= 1'b1;
                     busy   <= 1'b1;
                     state  <= S_ISSUE;
                  end
               end
               S_ISSUE: state <= S_WAIT;
               S_WAIT: begin
                  if (sad_valid) begin
                     lat_sad <= sad_in;
                     state   <= S_CMP;
                  end
               end
               S_CMP: begin
                  int_mvx <= win_mvx;
                  int_mvy <= win_mvy;
                  int_sad <= win_sad;
                  first   <= 1'b0;
                  cnt     <= cnt_inc;
                  if (finish) begin
                     best_mvx   <= win_mvx;
                     best_mvy   <= win_mvy;
                     best_sad   <= win_sad;
                     eval_count <= cnt_inc;
                     done       <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     pe_mvx <= nxt_mvx;
                     pe_mvy <= nxt_mvy;
                     pe_req <= 1'b1;
                     state  <= S_ISSUE;
                  end
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: table-driven search scenarios, abort/reset
// sequences and randomized searches checked against a window-scan model.
module tb_sad_search_ctrl;

   localparam int R    = 4;
   localparam int MW   = $clog2(R) + 1;
   localparam int CW   = 2 * MW + 1;
   localparam int SW   = 16;
   localparam int MW16 = 5;
   localparam int CW16 = 11;
   localparam int NCAND = 4 * R * R;

   logic clk = 1'b0;
   logic rst, start, abort, sad_valid;
   logic [SW-1:0] sad_in;

   logic                 pe_req, busy, done;
   logic signed [MW-1:0] pe_mvx, pe_mvy, best_mvx, best_mvy;
   logic [SW-1:0]        best_sad;
   logic [CW-1:0]        eval_count;

   logic                   pe_req16, busy16, done16;
   logic signed [MW16-1:0] pe_mvx16, pe_mvy16, best_mvx16, best_mvy16;
   logic [SW-1:0]          best_sad16;
   logic [CW16-1:0]        eval_count16;

   always #5 clk = ~clk;

   sad_search_ctrl #(.SEARCH_RANGE(R), .SAD_WIDTH(SW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pe_req(pe_req), .pe_mvx(pe_mvx), .pe_mvy(pe_mvy),
      .sad_valid(sad_valid), .sad_in(sad_in),
      .busy(busy), .done(done), .best_mvx(best_mvx), .best_mvy(best_mvy),
      .best_sad(best_sad), .eval_count(eval_count)
   );

   sad_search_ctrl #(.SEARCH_RANGE(16), .SAD_WIDTH(SW)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pe_req(pe_req16), .pe_mvx(pe_mvx16), .pe_mvy(pe_mvy16),
      .sad_valid(sad_valid), .sad_in(sad_in),
      .busy(busy16), .done(done16), .best_mvx(best_mvx16), .best_mvy(best_mvy16),
      .best_sad(best_sad16), .eval_count(eval_count16)
   );

   typedef struct {
      int pat;
      int l;
      int bx;
      int by;
      int bs;
      int n;
   } vec_t;

   int cost [0:2*R-1][0:2*R-1];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int lat      = 3;
   int pend     = 0;
   int rq_x     = 0;
   int rq_y     = 0;
   int req_idx  = 0;
   int exp_n    = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int d_bx, d_by, d_bs, d_n;
   bit noise_en  = 1'b0;
   bit resp_prev = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int cost_of(input int x, input int y);
      return cost[y+R][x+R];
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // One clock: sample outputs, act as SAD datapath, inject protocol noise.
   task automatic tick();
      bit real_resp;
      @(posedge clk);
      #1;
      cyc++;
      start     = 1'b0;
      abort     = 1'b0;
      sad_valid = 1'b0;
      sad_in    = SW'($urandom);
      real_resp = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            sad_valid = 1'b1;
            sad_in    = SW'(cost_of(rq_x, rq_y));
            real_resp = 1'b1;
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         d_bx = int'(best_mvx);
         d_by = int'(best_mvy);
         d_bs = int'(best_sad);
         d_n  = int'(eval_count);
      end
      if (pe_req) begin
         chk("req_allowed", int'(req_idx < exp_n), 1);
         chk("req_mvx", int'(pe_mvx), -R + req_idx % (2*R));
         chk("req_mvy", int'(pe_mvy), -R + req_idx / (2*R));
         req_idx++;
         rq_x = int'(pe_mvx);
         rq_y = int'(pe_mvy);
         pend = lat;
      end
      if (noise_en) begin
         if (!real_resp && (pe_req || resp_prev || !busy) && ($urandom_range(0, 1) == 1)) begin
            sad_valid = 1'b1;
            sad_in    = SW'($urandom);
         end
         if (busy && ($urandom_range(0, 2) == 0)) start = 1'b1;
      end
      resp_prev = real_resp;
   endtask

   task automatic fill(input int pat);
      for (int y = -R; y < R; y++) begin
         for (int x = -R; x < R; x++) begin
            case (pat)
               0:       cost[y+R][x+R] = 5 + iabs(x - 2) + iabs(y + 1);
               1, 2:    cost[y+R][x+R] = 200;
               3:       cost[y+R][x+R] = 100 + (x + R) + (y + R);
               4: begin
                  int v;
                  v = int'($urandom_range(0, 60));
                  cost[y+R][x+R] = (v == 0) ? 0 : 1 + v % 8;
               end
               default: cost[y+R][x+R] = int'($urandom_range(1, 20));
            endcase
         end
      end
      if (pat == 1) begin cost[0+R][-1+R] = 50; cost[0+R][1+R] = 50; end
      if (pat == 2) begin cost[0+R][-3+R] = 50; cost[1+R][1+R] = 50; end
      if (pat == 3) cost[-3+R][-4+R] = 0;
   endtask

   // Scan stops at the first zero SAD; winner is the lexicographic minimum of
   // (sad, L1 norm, scan index) over the evaluated prefix.
   task automatic model(output int bx, output int by, output int bs, output int n);
      longint best_key;
      n = NCAND;
      for (int i = 0; i < NCAND; i++) begin
         if (cost_of(-R + i % (2*R), -R + i / (2*R)) == 0) begin
            n = i + 1;
            break;
         end
      end
      best_key = -1;
      bx = 0; by = 0; bs = 0;
      for (int i = 0; i < n; i++) begin
         int x, y;
         longint key;
         x   = -R + i % (2*R);
         y   = -R + i / (2*R);
         key = longint'(cost_of(x, y)) * 65536 + longint'(iabs(x) + iabs(y)) * 256 + longint'(i);
         if (best_key < 0 || key < best_key) begin
            best_key = key;
            bx = x; by = y; bs = cost_of(x, y);
         end
      end
   endtask

   task automatic run_search(input int l, input string tag);
      int ebx, eby, ebs, en, t0;
      model(ebx, eby, ebs, en);
      lat      = l;
      req_idx  = 0;
      exp_n    = en;
      done_cnt = 0;
      start    = 1'b1;
      t0       = cyc;
      tick();
      chk({tag, "_first_req"}, int'(pe_req), 1);
      chk({tag, "_busy_rise"}, int'(busy), 1);
      while (done_cnt == 0 && (cyc - t0) < 3000) tick();
      chk({tag, "_done_seen"}, done_cnt, 1);
      chk({tag, "_done_time"}, done_cyc - t0, 1 + en * (l + 2));
      chk({tag, "_best_mvx"}, d_bx, ebx);
      chk({tag, "_best_mvy"}, d_by, eby);
      chk({tag, "_best_sad"}, d_bs, ebs);
      chk({tag, "_eval_count"}, d_n, en);
      tick();
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_busy_fall"}, int'(busy), 0);
      chk({tag, "_req_total"}, req_idx, en);
   endtask

   initial begin
      vec_t tbl[4];
      int t0;
      tbl[0] = '{0, 3,  2, -1,  5, 64};
      tbl[1] = '{1, 2, -1,  0, 50, 64};
      tbl[2] = '{2, 1,  1,  1, 50, 64};
      tbl[3] = '{3, 4, -4, -3,  0,  9};

      rst = 1'b1; start = 1'b1; abort = 1'b0; sad_valid = 1'b0; sad_in = '0;
      tick();
      start = 1'b1;
      tick();
      chk("rst_pe_req", int'(pe_req), 0);
      chk("rst_pe_mvx", int'(pe_mvx), 0);
      chk("rst_pe_mvy", int'(pe_mvy), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_best_mvx", int'(best_mvx), 0);
      chk("rst_best_mvy", int'(best_mvy), 0);
      chk("rst_best_sad", int'(best_sad), 0);
      chk("rst_eval_count", int'(eval_count), 0);
      chk("rst16_pe_req", int'(pe_req16), 0);
      chk("rst16_busy", int'(busy16), 0);
      chk("rst16_eval_count", int'(eval_count16), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_idle_req", int'(pe_req), 0);
      chk("post_rst_idle_busy", int'(busy), 0);
      lat = 3; req_idx = 0; exp_n = 1;
      start = 1'b1;
      tick();
      chk("first16_pe_req", int'(pe_req16), 1);
      chk("first16_busy", int'(busy16), 1);
      chk("first16_mvx", int'(pe_mvx16), -16);
      chk("first16_mvy", int'(pe_mvy16), -16);
      abort = 1'b1;
      tick();
      chk("issue_abort_busy", int'(busy), 0);
      chk("issue_abort_busy16", int'(busy16), 0);
      repeat (5) tick();

      for (int k = 0; k < 4; k++) begin
         fill(tbl[k].pat);
         run_search(tbl[k].l, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d_tbl_mvx", k), d_bx, tbl[k].bx);
         chk($sformatf("vec%0d_tbl_mvy", k), d_by, tbl[k].by);
         chk($sformatf("vec%0d_tbl_sad", k), d_bs, tbl[k].bs);
         chk($sformatf("vec%0d_tbl_cnt", k), d_n, tbl[k].n);
      end

      fill(0);
      run_search(3, "pre_abort");
      fill(5);
      lat = 3; req_idx = 0; exp_n = NCAND; done_cnt = 0;
      start = 1'b1;
      t0 = cyc;
      while (req_idx < 10 && (cyc - t0) < 1000) tick();
      chk("abort_reach_10th", req_idx, 10);
      tick();
      abort = 1'b1;
      start = 1'b1;
      exp_n = req_idx;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_pe_req", int'(pe_req), 0);
      chk("abort_done", int'(done), 0);
      repeat (12) tick();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_stay_idle", int'(busy), 0);
      chk("abort_no_req", req_idx, 10);
      chk("abort_keep_mvx", int'(best_mvx), 2);
      chk("abort_keep_mvy", int'(best_mvy), -1);
      chk("abort_keep_sad", int'(best_sad), 5);
      chk("abort_keep_cnt", int'(eval_count), 64);
      fill(4);
      run_search(2, "post_abort");

      noise_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         fill(4);
         run_search(int'($urandom_range(1, 4)), $sformatf("rnd%0d", k));
      end
      noise_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
